// File: rtl/dmem_sized.sv
// Data memory for the RV32 core: byte/half/word loads and stores on a valid/ready port,
// an RD_LAT-deep response pipeline, fault reporting, and an INIT_WORD sweep after reset.
module dmem_sized #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] INIT_WORD = 32'hdeadbeef,
  parameter int          RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic        rsp_valid,
  output logic [31:0] RD,
  output logic        fault,
  output logic        busy
);
  // state | meaning
  // INIT  | sweeping INIT_WORD into word[cnt], requests refused
  // RUN   | accepting one request per cycle
  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   cnt, cnt_nx;
  logic            init_we;
  logic [31:0]     mem [DEPTH];

  logic            accept;
  logic [AW-1:0]   widx;
  logic [31:0]     rd_word, sh_word, wr_word, ld_data;
  logic            lane_ok, bad_size, fault_c;

  logic            pv [RD_LAT];
  logic            pf [RD_LAT];
  logic [31:0]     pd [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    busy      = 1'b0;
    req_ready = 1'b0;
    init_we   = 1'b0;
    case (state)
      INIT: begin
        busy    = 1'b1;
        init_we = 1'b1;
        cnt_nx  = cnt + AW'(1);
        if (cnt == AW'(DEPTH - 1)) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      end
      RUN: req_ready = 1'b1;
      default: state_nx = INIT;
    endcase
  end

  assign accept  = req_valid && req_ready && !rst;
  assign widx    = A[AW+1:2];
  assign rd_word = mem[widx];
  assign sh_word = rd_word >> {A[1:0], 3'b000};

  always_comb begin
    lane_ok  = 1'b1;
    bad_size = 1'b0;
    case (req_size)
      3'b000, 3'b100: lane_ok = 1'b1;
      3'b001, 3'b101: lane_ok = !A[0];
      3'b010:         lane_ok = (A[1:0] == 2'b00);
      default:        bad_size = 1'b1;
    endcase
    fault_c = ({2'b00, A[31:2]} >= DEPTH_W) || bad_size || !lane_ok
              || (req_we && req_size[2]);
  end

  // Merge the store into the current word so unaddressed lanes are preserved.
  always_comb begin
    wr_word = rd_word;
    ld_data = '0;
    case (req_size)
      3'b000: begin
        wr_word[{A[1:0], 3'b000} +: 8] = WD[7:0];
        ld_data = {{24{sh_word[7]}}, sh_word[7:0]};
      end
      3'b001: begin
        wr_word[{A[1], 4'b0000} +: 16] = WD[15:0];
        ld_data = {{16{sh_word[15]}}, sh_word[15:0]};
      end
      3'b010: begin
        wr_word = WD;
        ld_data = rd_word;
      end
      3'b100:  ld_data = {24'h0, sh_word[7:0]};
      3'b101:  ld_data = {16'h0, sh_word[15:0]};
      default: ld_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (init_we && !rst)
      mem[cnt] <= INIT_WORD;
    else if (accept && req_we && !fault_c)
      mem[widx] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pv[i] <= 1'b0;
        pf[i] <= 1'b0;
        pd[i] <= '0;
      end
      rsp_valid <= 1'b0;
      RD        <= '0;
      fault     <= 1'b0;
    end else begin
      pv[0] <= accept;
      pf[0] <= accept && fault_c;
      pd[0] <= (accept && !req_we && !fault_c) ? ld_data : 32'h0;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pf[i] <= pf[i-1];
        pd[i] <= pd[i-1];
      end
      rsp_valid <= pv[RD_LAT-1];
      RD        <= pd[RD_LAT-1];
      fault     <= pf[RD_LAT-1];
    end
  end
endmodule

// File: tb/tb_dmem_sized.sv
// Scoreboard bench for dmem_sized: two instances (RD_LAT=1 and RD_LAT=3) share stimulus,
// a byte-array reference model predicts every response and its arrival cycle.
module tb_dmem_sized;
  logic        clk, rst;
  logic        req_valid, req_we;
  logic [2:0]  req_size;
  logic [31:0] A, WD;

  logic        ready1, rv1, f1, busy1;
  logic [31:0] rd1;
  logic        ready3, rv3, f3, busy3;
  logic [31:0] rd3;

  typedef struct {
    logic [31:0] rd;
    logic        f;
    int          cyc;
  } exp_t;

  exp_t        q1[$];
  exp_t        q3[$];
  logic [7:0]  mb [256];
  int          cyc;
  int          total, bad;
  bit          mon_en;

  dmem_sized #(.DEPTH(64), .INIT_WORD(32'hdeadbeef), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1), .req_we(req_we),
    .req_size(req_size), .A(A), .WD(WD), .rsp_valid(rv1), .RD(rd1), .fault(f1), .busy(busy1)
  );

  dmem_sized #(.DEPTH(64), .INIT_WORD(32'hdeadbeef), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready3), .req_we(req_we),
    .req_size(req_size), .A(A), .WD(WD), .rsp_valid(rv3), .RD(rd3), .fault(f3), .busy(busy3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (q1.size() > 0 && q1[0].cyc < cyc) begin
        check_val("lat1_missing_rsp", 0, 1);
        void'(q1.pop_front());
      end
      if (rv1) begin
        if (q1.size() == 0) check_val("lat1_unexpected_rsp", 1, 0);
        else begin
          exp_t e;
          e = q1.pop_front();
          check_val("lat1_rd", rd1, e.rd);
          check_val("lat1_fault", f1, e.f);
          check_val("lat1_cycle", cyc, e.cyc);
        end
      end else check_val("lat1_idle", {rd1, f1}, 33'h0);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (q3.size() > 0 && q3[0].cyc < cyc) begin
        check_val("lat3_missing_rsp", 0, 1);
        void'(q3.pop_front());
      end
      if (rv3) begin
        if (q3.size() == 0) check_val("lat3_unexpected_rsp", 1, 0);
        else begin
          exp_t e;
          e = q3.pop_front();
          check_val("lat3_rd", rd3, e.rd);
          check_val("lat3_fault", f3, e.f);
          check_val("lat3_cycle", cyc, e.cyc);
        end
      end else check_val("lat3_idle", {rd3, f3}, 33'h0);
    end
  end

  // Drive one request for the next edge; the model predicts its response.
  task automatic req(input bit we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    bit          f;
    logic [31:0] r;
    logic [7:0]  ba;
    exp_t        e;
    f  = (a[31:2] >= 30'd64);
    ba = a[7:0];
    case (sz)
      3'b000, 3'b100: ;
      3'b001, 3'b101: if (a[0]) f = 1'b1;
      3'b010:         if (a[1:0] != 2'b00) f = 1'b1;
      default:        f = 1'b1;
    endcase
    if (we && (sz == 3'b100 || sz == 3'b101)) f = 1'b1;
    r = 32'h0;
    if (!f) begin
      if (we) begin
        mb[ba] = wd[7:0];
        if (sz != 3'b000) mb[ba + 8'd1] = wd[15:8];
        if (sz == 3'b010) begin
          mb[ba + 8'd2] = wd[23:16];
          mb[ba + 8'd3] = wd[31:24];
        end
      end else begin
        case (sz)
          3'b000: r = {{24{mb[ba][7]}}, mb[ba]};
          3'b100: r = {24'h0, mb[ba]};
          3'b001: r = {{16{mb[ba + 8'd1][7]}}, mb[ba + 8'd1], mb[ba]};
          3'b101: r = {16'h0, mb[ba + 8'd1], mb[ba]};
          default: r = {mb[ba + 8'd3], mb[ba + 8'd2], mb[ba + 8'd1], mb[ba]};
        endcase
      end
    end
    e.rd  = r;
    e.f   = f;
    e.cyc = cyc + 2;
    q1.push_back(e);
    e.cyc = cyc + 4;
    q3.push_back(e);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = sz;
    A         = a;
    WD        = wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Called at a negedge with rst just released: exactly 64 busy cycles, then ready.
  task automatic sweep();
    for (int i = 0; i < 64; i++) begin
      check_val("init_busy_lat1", {busy1, ready1}, 2'b10);
      check_val("init_busy_lat3", {busy3, ready3}, 2'b10);
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    check_val("run_ready_lat1", {busy1, ready1}, 2'b01);
    check_val("run_ready_lat3", {busy3, ready3}, 2'b01);
    for (int i = 0; i < 256; i += 4) begin
      mb[i]     = 8'hef;
      mb[i + 1] = 8'hbe;
      mb[i + 2] = 8'had;
      mb[i + 3] = 8'hde;
    end
  endtask

  // Reset at the next edge, holding a store request on the port through the sweep.
  task automatic reset_with_held_req();
    int lim;
    rst = 1'b1;
    lim = cyc + 1;
    for (int i = q1.size() - 1; i >= 0; i--) if (q1[i].cyc >= lim) q1.delete(i);
    for (int i = q3.size() - 1; i >= 0; i--) if (q3[i].cyc >= lim) q3.delete(i);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 3'b010;
    A         = 32'h0;
    WD        = 32'h00000055;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sweep();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 3'b010;
    A = 32'h0;
    WD = 32'h0;
    cyc = 0;
    total = 0;
    bad = 0;
    mon_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_outs_lat1", {rv1, rd1, f1, busy1, ready1}, {1'b0, 32'h0, 1'b0, 1'b1, 1'b0});
    check_val("reset_outs_lat3", {rv3, rd3, f3, busy3, ready3}, {1'b0, 32'h0, 1'b0, 1'b1, 1'b0});
    mon_en = 1'b1;
    rst = 1'b0;
    sweep();

    req(0, 3'b010, 32'h0, 0);
    req(0, 3'b010, 32'hfc, 0);
    idle(4);

    req(1, 3'b000, 32'h11, 32'h000000a5);
    req(0, 3'b010, 32'h10, 0);
    req(0, 3'b000, 32'h11, 0);
    req(0, 3'b100, 32'h11, 0);
    req(1, 3'b001, 32'h12, 32'h00001234);
    req(0, 3'b101, 32'h12, 0);
    req(1, 3'b001, 32'h22, 32'h0000f00d);
    req(0, 3'b001, 32'h22, 0);
    req(0, 3'b000, 32'h20, 0);
    idle(4);

    req(1, 3'b001, 32'h13, 32'h0000ffff);
    req(0, 3'b010, 32'h10, 0);
    req(0, 3'b010, 32'h100, 0);
    req(1, 3'b100, 32'h10, 32'h000000ff);
    req(0, 3'b010, 32'h10, 0);
    req(0, 3'b010, 32'h102, 0);
    req(0, 3'b011, 32'h10, 0);
    req(1, 3'b010, 32'hfffffff0, 32'h1);
    idle(4);

    req(1, 3'b010, 32'h0, 32'd1);
    req(1, 3'b010, 32'h4, 32'd2);
    req(1, 3'b010, 32'h8, 32'd3);
    req(1, 3'b010, 32'hc, 32'd4);
    req(0, 3'b010, 32'h0, 0);
    req(0, 3'b010, 32'h4, 0);
    req(0, 3'b010, 32'h8, 0);
    req(0, 3'b010, 32'hc, 0);
    idle(6);

    req(0, 3'b010, 32'h0, 0);
    req(0, 3'b010, 32'h4, 0);
    reset_with_held_req();
    req(0, 3'b010, 32'h0, 0);
    req(0, 3'b010, 32'h4, 0);
    idle(8);

    check_val("lat1_queue_drained", q1.size(), 0);
    check_val("lat3_queue_drained", q3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
